// File: rtl/clock_pkg.sv
// Shared constants and FSM encoding for the clock front-panel controller.
package clock_pkg;

    localparam int unsigned MODE_CLOCK     = 0;
    localparam int unsigned MODE_ALARM     = 1;
    localparam int unsigned MODE_STOPWATCH = 2;
    localparam int unsigned MODE_TIMER     = 3;

    localparam logic [1:0] FIELD_SEC = 2'd0;
    localparam logic [1:0] FIELD_MIN = 2'd1;
    localparam logic [1:0] FIELD_HR  = 2'd2;

    localparam int unsigned HR_W  = 5;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned SEC_W = 6;

    typedef enum logic {
        RUN  = 1'b0,
        EDIT = 1'b1
    } state_t;

endpackage

// File: rtl/ms_interval_timer.sv
// Counts ms strobes up to LIMIT; o_tc flags the strobe that completes an interval.
module ms_interval_timer #(
    parameter int unsigned LIMIT = 500
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_tc
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last = (cnt_q == CW'(LIMIT - 1));
    assign o_tc = i_tick && !i_clr && last;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_tick)
            cnt_d = last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clock_mode_controller.sv
// Front-panel sequencer: mode select, edit cursor, blink and button routing.
// Optional edit timeout enabled by defining CLOCK_MODE_AUTO_EXIT_EN.
module clock_mode_controller
    import clock_pkg::*;
#(
    parameter int unsigned NUM_MODES  = 4,
    parameter int unsigned BLINK_MS   = 500,
    parameter int unsigned TIMEOUT_MS = 10000,
    localparam int unsigned MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_ms_pulse,
    input  logic                     i_mode,
    input  logic                     i_set,
    input  logic                     i_up,
    input  logic                     i_down,
    input  logic                     i_left,
    input  logic                     i_right,
    input  logic [5*NUM_MODES-1:0]   i_hr_bus,
    input  logic [6*NUM_MODES-1:0]   i_min_bus,
    input  logic [6*NUM_MODES-1:0]   i_sec_bus,
    output logic [NUM_MODES-1:0]     o_set,
    output logic [NUM_MODES-1:0]     o_up,
    output logic [NUM_MODES-1:0]     o_down,
    output logic [NUM_MODES-1:0]     o_left,
    output logic [NUM_MODES-1:0]     o_right,
    output logic [MODE_W-1:0]        o_mode,
    output logic                     o_edit,
    output logic [1:0]               o_field,
    output logic [2:0]               o_blank,
    output logic [HR_W-1:0]          o_hr,
    output logic [MIN_W-1:0]         o_min,
    output logic [SEC_W-1:0]         o_sec
);

    state_t               state_q, state_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [1:0]           field_q, field_d;
    logic                 hidden_q, hidden_d;
    logic [2:0]           blank_q, blank_d;
    logic [NUM_MODES-1:0] set_q, set_d, up_q, up_d, down_q, down_d;
    logic [NUM_MODES-1:0] left_q, left_d, right_q, right_d;
    logic [HR_W-1:0]      hr_q;
    logic [MIN_W-1:0]     min_q;
    logic [SEC_W-1:0]     sec_q;

    logic [NUM_MODES-1:0] sel;
    logic                 lr_evt, ud_evt, accepted, any_btn;
    logic                 in_edit, blink_tc, timeout_tc;

    assign sel     = NUM_MODES'(1) << mode_q;
    assign lr_evt  = i_left ^ i_right;
    assign ud_evt  = i_up ^ i_down;
    assign any_btn = i_mode | i_set | i_up | i_down | i_left | i_right;
    assign in_edit = (state_q == EDIT);

    ms_interval_timer #(.LIMIT(BLINK_MS)) u_blink (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_tick (i_ms_pulse && in_edit),
        .i_clr  (accepted || !in_edit),
        .o_tc   (blink_tc)
    );

`ifdef CLOCK_MODE_AUTO_EXIT_EN
    ms_interval_timer #(.LIMIT(TIMEOUT_MS)) u_timeout (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_tick (i_ms_pulse && in_edit),
        .i_clr  (any_btn || !in_edit),
        .o_tc   (timeout_tc)
    );
`else
    assign timeout_tc = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        field_d  = field_q;
        hidden_d = hidden_q;
        set_d    = '0;
        up_d     = '0;
        down_d   = '0;
        left_d   = '0;
        right_d  = '0;
        accepted = 1'b0;
        case (state_q)
            RUN: begin
                if (i_set) begin
                    state_d  = EDIT;
                    field_d  = FIELD_SEC;
                    hidden_d = 1'b0;
                    set_d    = sel;
                end else if (i_mode) begin
                    mode_d = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
                end else if (lr_evt) begin
                    left_d  = i_left  ? sel : '0;
                    right_d = i_right ? sel : '0;
                end else if (ud_evt) begin
                    up_d   = i_up   ? sel : '0;
                    down_d = i_down ? sel : '0;
                end
            end
            EDIT: begin
                // i_mode is not an event here, so it does not mask lower buttons
                if (i_set || timeout_tc) begin
                    accepted = i_set;
                    state_d  = RUN;
                    hidden_d = 1'b0;
                    set_d    = sel;
                end else if (lr_evt) begin
                    accepted = 1'b1;
                    if (i_left)
                        field_d = (field_q == FIELD_HR) ? FIELD_SEC : field_q + 2'd1;
                    else
                        field_d = (field_q == FIELD_SEC) ? FIELD_HR : field_q - 2'd1;
                end else if (ud_evt) begin
                    accepted = 1'b1;
                    up_d     = i_up   ? sel : '0;
                    down_d   = i_down ? sel : '0;
                end
                if (state_d == EDIT) begin
                    if (accepted)
                        hidden_d = 1'b0;
                    else if (blink_tc)
                        hidden_d = !hidden_q;
                end
            end
            default: state_d = RUN;
        endcase
        blank_d = (state_d == EDIT && hidden_d) ? (3'b001 << field_d) : 3'b000;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= RUN;
            mode_q   <= MODE_W'(MODE_CLOCK);
            field_q  <= FIELD_SEC;
            hidden_q <= 1'b0;
            blank_q  <= '0;
            set_q    <= '0;
            up_q     <= '0;
            down_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            hr_q     <= '0;
            min_q    <= '0;
            sec_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            field_q  <= field_d;
            hidden_q <= hidden_d;
            blank_q  <= blank_d;
            set_q    <= set_d;
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
            // Mux follows the registered mode, adding one cycle after a mode change
            hr_q     <= i_hr_bus[mode_q*HR_W +: HR_W];
            min_q    <= i_min_bus[mode_q*MIN_W +: MIN_W];
            sec_q    <= i_sec_bus[mode_q*SEC_W +: SEC_W];
        end
    end

    assign o_set   = set_q;
    assign o_up    = up_q;
    assign o_down  = down_q;
    assign o_left  = left_q;
    assign o_right = right_q;
    assign o_mode  = mode_q;
    assign o_edit  = (state_q == EDIT);
    assign o_field = field_q;
    assign o_blank = blank_q;
    assign o_hr    = hr_q;
    assign o_min   = min_q;
    assign o_sec   = sec_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Scoreboard bench for clock_mode_controller; the timeout model follows CLOCK_MODE_AUTO_EXIT_EN.
module tb_clock_mode_controller;

    localparam int N       = 4;
    localparam int BLINK   = 2;
    localparam int TIMEOUT = 5;

    logic clk, rstn, ms, b_mode, b_set, b_up, b_down, b_left, b_right;
    logic [5*N-1:0] hr_bus;
    logic [6*N-1:0] min_bus, sec_bus;
    logic [N-1:0] o_set, o_up, o_down, o_left, o_right;
    logic [1:0] o_mode, o_field;
    logic o_edit;
    logic [2:0] o_blank;
    logic [4:0] o_hr;
    logic [5:0] o_min, o_sec;

    clock_mode_controller #(.NUM_MODES(N), .BLINK_MS(BLINK), .TIMEOUT_MS(TIMEOUT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_ms_pulse(ms),
        .i_mode(b_mode), .i_set(b_set), .i_up(b_up), .i_down(b_down),
        .i_left(b_left), .i_right(b_right),
        .i_hr_bus(hr_bus), .i_min_bus(min_bus), .i_sec_bus(sec_bus),
        .o_set(o_set), .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
        .o_mode(o_mode), .o_edit(o_edit), .o_field(o_field), .o_blank(o_blank),
        .o_hr(o_hr), .o_min(o_min), .o_sec(o_sec)
    );

    typedef struct packed {
        logic [N-1:0] set, up, down, left, right;
        logic [1:0]   mode;
        logic         edit;
        logic [1:0]   field;
        logic [2:0]   blank;
        logic [4:0]   hr;
        logic [5:0]   mn, sc;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_mode = 0, m_field = 0, m_blink = 0, m_to = 0;
    bit m_edit = 0, m_hidden = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t model_step(input bit r, t, md, st, up, dn, lf, rt);
        obs_t e;
        bit fire, acc;
        e = '0;
        if (!r) begin
            m_mode = 0; m_field = 0; m_blink = 0; m_to = 0; m_edit = 0; m_hidden = 0;
            return e;
        end
        e.hr = hr_bus[m_mode*5 +: 5];
        e.mn = min_bus[m_mode*6 +: 6];
        e.sc = sec_bus[m_mode*6 +: 6];
        if (!m_edit) begin
            if (st) begin
                e.set[m_mode] = 1;
                m_edit = 1; m_field = 0; m_blink = 0; m_hidden = 0; m_to = 0;
            end else if (md) begin
                m_mode = (m_mode + 1) % N;
            end else if (lf != rt) begin
                e.left[m_mode] = lf;
                e.right[m_mode] = rt;
            end else if (up != dn) begin
                e.up[m_mode] = up;
                e.down[m_mode] = dn;
            end
        end else begin
            fire = 0;
`ifdef CLOCK_MODE_AUTO_EXIT_EN
            if (md | st | up | dn | lf | rt) m_to = 0;
            else if (t) begin
                m_to++;
                if (m_to == TIMEOUT) begin fire = 1; m_to = 0; end
            end
`endif
            if (st || fire) begin
                e.set[m_mode] = 1;
                m_edit = 0; m_hidden = 0; m_blink = 0; m_to = 0;
            end else begin
                acc = 0;
                if (lf != rt) begin
                    m_field = lf ? (m_field + 1) % 3 : (m_field + 2) % 3;
                    acc = 1;
                end else if (up != dn) begin
                    e.up[m_mode] = up;
                    e.down[m_mode] = dn;
                    acc = 1;
                end
                if (acc) begin
                    m_blink = 0; m_hidden = 0;
                end else if (t) begin
                    m_blink++;
                    if (m_blink == BLINK) begin m_blink = 0; m_hidden = !m_hidden; end
                end
            end
        end
        e.mode  = 2'(m_mode);
        e.edit  = m_edit;
        e.field = 2'(m_field);
        e.blank = (m_edit && m_hidden) ? 3'(1 << m_field) : 3'b000;
        return e;
    endfunction

    task automatic drive(input bit r, t, md, st, up, dn, lf, rt);
        @(negedge clk);
        rstn = r; ms = t; b_mode = md; b_set = st;
        b_up = up; b_down = dn; b_left = lf; b_right = rt;
        for (int k = 0; k < N; k++) begin
            hr_bus[k*5 +: 5]  = 5'($urandom_range(0, 23));
            min_bus[k*6 +: 6] = 6'($urandom_range(0, 59));
            sec_bus[k*6 +: 6] = 6'($urandom_range(0, 59));
        end
        exp_q.push_back(model_step(r, t, md, st, up, dn, lf, rt));
    endtask

    task automatic idle(input bit t);
        drive(1, t, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every registered output is live each cycle, so compare once per edge
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{o_set, o_up, o_down, o_left, o_right, o_mode, o_edit,
                      o_field, o_blank, o_hr, o_min, o_sec};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got set=%b up=%b dn=%b lf=%b rt=%b mode=%0d edit=%b field=%0d blank=%b hms=%0d:%0d:%0d want set=%b up=%b dn=%b lf=%b rt=%b mode=%0d edit=%b field=%0d blank=%b hms=%0d:%0d:%0d",
                             $time, a.set, a.up, a.down, a.left, a.right, a.mode, a.edit,
                             a.field, a.blank, a.hr, a.mn, a.sc,
                             e.set, e.up, e.down, e.left, e.right, e.mode, e.edit,
                             e.field, e.blank, e.hr, e.mn, e.sc);
                end
            end
        end
    end

    initial begin
        int dens;
        bit r, t, md, st, up, dn, lf, rt;
        rstn = 0; ms = 0; b_mode = 0; b_set = 0; b_up = 0; b_down = 0; b_left = 0; b_right = 0;
        hr_bus = '0; min_bus = '0; sec_bus = '0;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        // Mode stepping 1,2,3,0 then back to 2
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 0);
            idle(0);
            idle(0);
        end
        drive(1, 0, 0, 0, 1, 0, 0, 0);          // up routed in RUN
        idle(0);
        drive(1, 0, 0, 0, 1, 1, 0, 0);          // up+down dropped
        drive(1, 0, 0, 0, 0, 0, 1, 1);          // left+right dropped
        drive(1, 0, 0, 0, 0, 0, 0, 1);          // right routed in RUN
        drive(1, 0, 0, 1, 0, 0, 0, 0);          // enter EDIT
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin idle(1); idle(0); end
        drive(1, 1, 0, 0, 1, 0, 0, 0);          // up with ms strobe restarts blink
        for (int i = 0; i < 3; i++) idle(1);
        drive(1, 1, 1, 1, 0, 0, 0, 0);          // set exits EDIT
        drive(1, 0, 1, 1, 1, 0, 0, 0);          // set+mode+up in RUN
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);          // reset while editing
        idle(0);
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) idle(1);    // timeout window
        drive(1, 0, 0, 1, 0, 0, 0, 0);

        dens = 8;
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) dens = $urandom_range(3, 40);
            r  = ($urandom_range(0, 399) != 0);
            t  = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, dens - 1) == 0);
            st = ($urandom_range(0, 3 * dens - 1) == 0);
            up = ($urandom_range(0, dens - 1) == 0);
            dn = ($urandom_range(0, dens - 1) == 0);
            lf = ($urandom_range(0, dens - 1) == 0);
            rt = ($urandom_range(0, dens - 1) == 0);
            drive(r, t, md, st, up, dn, lf, rt);
        end

        idle(0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
